// File: rtl/pin_cmd_scheduler.sv
// Queues SPI pin commands in a small FIFO and applies them to the 64-bit pin
// register one at a time, each followed by a fixed HOLD interval.
module pin_cmd_scheduler #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   cmd_valid,
   input  logic [7:0]             cmd_byte,
   output logic                   cmd_ready,
   input  logic                   en,
   input  logic                   ovf_clr,
   output logic [63:0]            pins,
   output logic                   applied,
   output logic                   busy,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLD} state_t;

   state_t        state_q;
   logic [CW-1:0] hold_q;
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   level_q, level_d;
   logic [63:0]   pins_q, pins_d;
   logic          applied_q;
   logic          overflow_q;
   logic [7:0]    mem_q [DEPTH];
   logic          push, pop;

   function automatic logic [63:0] apply_cmd(input logic [63:0] p, input logic [7:0] c);
      logic [63:0] r;
      r = p;
      case (c[7:6])
         2'b00:   r[c[5:0]] = ~p[c[5:0]];
         2'b01:   r[c[5:0]] = 1'b1;
         2'b10:   r[c[5:0]] = 1'b0;
         default: r = '0;
      endcase
      return r;
   endfunction

   assign cmd_ready = (level_q != FULL);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_APPLY);
   assign pins_d    = apply_cmd(pins_q, mem_q[rd_q]);

   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + 1'b1;
      else if (!push && pop)
         level_d = level_q - 1'b1;
   end

   // Payload storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge CLK) begin
      if (push)
         mem_q[wr_q] <= cmd_byte;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         level_q    <= '0;
         pins_q     <= '0;
         applied_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         applied_q <= 1'b0;
         level_q   <= level_d;
         if (push)
            wr_q <= wr_q + 1'b1;
         if (cmd_valid && !cmd_ready)
            overflow_q <= 1'b1;
         else if (ovf_clr)
            overflow_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (en && (level_q != '0))
                  state_q <= S_APPLY;
            end
            S_APPLY: begin
               rd_q      <= rd_q + 1'b1;
               pins_q    <= pins_d;
               applied_q <= 1'b1;
               hold_q    <= HOLD_LOAD;
               state_q   <= S_HOLD;
            end
            S_HOLD: begin
               if (hold_q == '0)
                  state_q <= S_IDLE;
               else
                  hold_q <= hold_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pins     = pins_q;
   assign applied  = applied_q;
   assign overflow = overflow_q;
   assign level    = level_q;
   assign busy     = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_pin_cmd_scheduler.sv
// Scoreboard bench for pin_cmd_scheduler: a queue-based reference model predicts
// every pin update and per-cycle status; a monitor compares after each edge.
module tb_pin_cmd_scheduler;
   localparam int DEPTH = 4;
   localparam int HOLD  = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [7:0]    cmd_byte = 8'h00;
   logic          en = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          cmd_ready;
   logic [63:0]   pins;
   logic          applied;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] level;

   pin_cmd_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .cmd_ready(cmd_ready), .en(en), .ovf_clr(ovf_clr), .pins(pins),
      .applied(applied), .busy(busy), .overflow(overflow), .level(level)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: pending command queue, a slot countdown and the pin image.
   // phase 0 = idle, HOLD+1 = apply cycle, HOLD..1 = remaining hold cycles.
   logic [7:0]  mq[$];
   logic [63:0] exp_q[$];
   logic [63:0] m_pins = '0;
   bit          m_applied = 0;
   bit          m_ovf = 0;
   int          phase = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_apply(input logic [63:0] p, input logic [7:0] c);
      logic [63:0] r;
      int idx;
      r = p;
      idx = int'(c[5:0]);
      case (c[7:6])
         2'b00: r[idx] = ~r[idx];
         2'b01: r[idx] = 1'b1;
         2'b10: r[idx] = 1'b0;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_edge();
      bit rdy;
      logic [7:0] head;
      rdy = (mq.size() != DEPTH);
      m_applied = 0;
      if (phase == 0) begin
         if (en && mq.size() != 0) phase = HOLD + 1;
      end else if (phase == HOLD + 1) begin
         head = mq.pop_front();
         m_pins = ref_apply(m_pins, head);
         exp_q.push_back(m_pins);
         m_applied = 1;
         phase = HOLD;
      end else begin
         phase = phase - 1;
      end
      if (cmd_valid && rdy) mq.push_back(cmd_byte);
      if (cmd_valid && !rdy) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit e, input bit c);
      @(negedge CLK);
      cmd_valid = v;
      cmd_byte  = b;
      en        = e;
      ovf_clr   = c;
      model_edge();
   endtask

   task automatic idle(input int n, input bit e);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, e, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      cmd_valid = 1'b0;
      ovf_clr = 1'b0;
      en = 1'b0;
      mq.delete();
      exp_q.delete();
      m_pins = '0;
      m_applied = 0;
      m_ovf = 0;
      phase = 0;
      #1;
      chk("rst_pins", pins, 64'h0);
      chk("rst_level", 64'(level), 64'h0);
      chk("rst_ready", 64'(cmd_ready), 64'h1);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ovf", 64'(overflow), 64'h0);
      chk("rst_applied", 64'(applied), 64'h0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      model_edge();
   endtask

   // Monitor: compares the DUT against the model just after every rising edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         chk("applied", 64'(applied), 64'(m_applied));
         chk("pins", pins, m_pins);
         chk("level", 64'(level), 64'(mq.size()));
         chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() != DEPTH));
         chk("busy", 64'(busy), 64'(phase != 0 || mq.size() != 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (applied) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: applied=1 with no expected update at %0t", $time);
            end else begin
               chk("sb_pins", pins, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset();

      // Toggle pin 0 twice: first change two edges after push, second 4 edges later.
      step(1'b1, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_before_e2", pins, 64'h0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_pins_e2", pins, 64'h1);
      chk("t1_applied_e2", 64'(applied), 64'h1);
      idle(6, 1'b1);
      chk("t1_pins_end", pins, 64'h0);
      chk("t1_busy_end", 64'(busy), 64'h0);

      // Opcode mix.
      step(1'b1, 8'h43, 1'b1, 1'b0);
      step(1'b1, 8'h7F, 1'b1, 1'b0);
      step(1'b1, 8'h83, 1'b1, 1'b0);
      idle(14, 1'b1);
      chk("t2_mix", pins, 64'h8000000000000000);
      step(1'b1, 8'hC0, 1'b1, 1'b0);
      idle(6, 1'b1);
      chk("t2_clr_all", pins, 64'h0);

      // Overflow with en low.
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("t3_level", 64'(level), 64'd4);
      chk("t3_ready", 64'(cmd_ready), 64'h0);
      chk("t3_ovf", 64'(overflow), 64'h1);
      idle(20, 1'b1);
      chk("t3_pins", pins, 64'h1E);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      idle(1, 1'b1);
      chk("t3_ovf_clr", 64'(overflow), 64'h0);

      // Enable gating.
      do_reset();
      step(1'b1, 8'h41, 1'b1, 1'b0);
      step(1'b1, 8'h42, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(8, 1'b0);
      chk("t4_pins", pins, 64'h2);
      chk("t4_level", 64'(level), 64'd1);
      idle(3, 1'b1);
      chk("t4_pins_resume", pins, 64'h6);

      // Reset during HOLD discards queued work.
      idle(4, 1'b1);
      step(1'b1, 8'h01, 1'b1, 1'b0);
      step(1'b1, 8'h02, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b1, 1'b0);
      idle(1, 1'b1);
      do_reset();
      idle(10, 1'b1);
      chk("t5_pins", pins, 64'h0);
      chk("t5_level", 64'(level), 64'h0);

      // Push on the pop edge keeps level, then pointer wrap over more commands.
      step(1'b1, 8'h44, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h45, 1'b1, 1'b0);
      idle(1, 1'b1);
      chk("t6_level_pushpop", 64'(level), 64'd1);
      for (int i = 6; i < 12; i++) begin
         while (mq.size() == DEPTH) idle(1, 1'b1);
         step(1'b1, 8'h40 | 8'(i), 1'b1, 1'b0);
      end
      idle(40, 1'b1);
      chk("t6_pins", pins, 64'hFF0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 9) != 0,
              $urandom_range(0, 15) == 0);
      end
      idle(40, 1'b1);
      chk("drain_sb_empty", 64'(exp_q.size()), 64'h0);
      chk("drain_level", 64'(level), 64'h0);

      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
